// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle integer ALU with valid/ready handshake and a
//                registered result. Single-cycle ops finish in one cycle;
//                IMUL (shift-add) takes WIDTH+1 cycles. Build option macro
//                ALU_MC_DIV_EN adds a restoring divider for IDIV/IDIVU/IREM/
//                IREMU; without it those opcodes return 0 in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_ovf
);
    localparam int SHAMT_W = $clog2(WIDTH);

    // Opcode encoding
    localparam logic [4:0] c_IADD  = 5'd0;
    localparam logic [4:0] c_IAND  = 5'd1;
    localparam logic [4:0] c_IOR   = 5'd2;
    localparam logic [4:0] c_IXOR  = 5'd3;
    localparam logic [4:0] c_IPAS  = 5'd4;
    localparam logic [4:0] c_ISUB  = 5'd5;
    localparam logic [4:0] c_ILT   = 5'd6;
    localparam logic [4:0] c_ILTU  = 5'd7;
    localparam logic [4:0] c_IGE   = 5'd8;
    localparam logic [4:0] c_IGEU  = 5'd9;
    localparam logic [4:0] c_IEQ   = 5'd10;
    localparam logic [4:0] c_INE   = 5'd11;
    localparam logic [4:0] c_ISLL  = 5'd12;
    localparam logic [4:0] c_ISRL  = 5'd13;
    localparam logic [4:0] c_ISRA  = 5'd14;
    localparam logic [4:0] c_IMUL  = 5'd15;
    localparam logic [4:0] c_IDIV  = 5'd16;
    localparam logic [4:0] c_IDIVU = 5'd17;
    localparam logic [4:0] c_IREM  = 5'd18;
    localparam logic [4:0] c_IREMU = 5'd19;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               w_accept;
    logic               w_is_div;
    logic               w_is_iter;
    logic               w_last;

    // Single-cycle datapath signals
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_ovf_add;
    logic               w_ovf_sub;
    logic               w_lt;
    logic               w_ltu;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;

    // Multiplier working state
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   w_acc_nx;
    logic [WIDTH-1:0]   w_iter_res;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_CNT_LAST);

`ifdef ALU_MC_DIV_EN
    assign w_is_div = (instruction == c_IDIV)  || (instruction == c_IDIVU) ||
                      (instruction == c_IREM)  || (instruction == c_IREMU);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_is_iter = (instruction == c_IMUL) || w_is_div;

    // Adder/subtractor with zero-extended operands; top bit is carry/borrow
    assign w_sum     = {1'b0, in_a} + {1'b0, in_b};
    assign w_diff    = {1'b0, in_a} - {1'b0, in_b};
    // Signed overflow = carry into MSB xor carry out of MSB
    assign w_ovf_add = w_sum[WIDTH] ^ in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_ovf_sub = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
    assign w_ltu     = w_diff[WIDTH];
    assign w_lt      = w_diff[WIDTH-1] ^ w_ovf_sub;
    assign w_shamt   = in_b[SHAMT_W-1:0];

    // Single-cycle result selection; unknown opcodes behave as subtract
    always_comb begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_ovf = w_ovf_sub;
        case (instruction)
            c_IADD:  begin w_alu_res = w_sum[WIDTH-1:0]; w_alu_ovf = w_ovf_add; end
            c_IAND:  begin w_alu_res = in_a & in_b;      w_alu_ovf = 1'b0; end
            c_IOR:   begin w_alu_res = in_a | in_b;      w_alu_ovf = 1'b0; end
            c_IXOR:  begin w_alu_res = in_a ^ in_b;      w_alu_ovf = 1'b0; end
            c_IPAS:  begin w_alu_res = in_b;             w_alu_ovf = 1'b0; end
            c_ISUB:  begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_ovf = w_ovf_sub; end
            c_ILT:   begin w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};   w_alu_ovf = 1'b0; end
            c_ILTU:  begin w_alu_res = {{(WIDTH-1){1'b0}}, w_ltu};  w_alu_ovf = 1'b0; end
            c_IGE:   begin w_alu_res = {{(WIDTH-1){1'b0}}, ~w_lt};  w_alu_ovf = 1'b0; end
            c_IGEU:  begin w_alu_res = {{(WIDTH-1){1'b0}}, ~w_ltu}; w_alu_ovf = 1'b0; end
            c_IEQ:   begin w_alu_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)}; w_alu_ovf = 1'b0; end
            c_INE:   begin w_alu_res = {{(WIDTH-1){1'b0}}, (in_a != in_b)}; w_alu_ovf = 1'b0; end
            c_ISLL:  begin w_alu_res = in_a << w_shamt;  w_alu_ovf = 1'b0; end
            c_ISRL:  begin w_alu_res = in_a >> w_shamt;  w_alu_ovf = 1'b0; end
            c_ISRA:  begin w_alu_res = $signed(in_a) >>> w_shamt; w_alu_ovf = 1'b0; end
            // Iterative ops overwrite the result later; divides land here when the divider is absent
            c_IMUL, c_IDIV, c_IDIVU, c_IREM, c_IREMU:
                     begin w_alu_res = '0;               w_alu_ovf = 1'b0; end
            default: begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_ovf = w_ovf_sub; end
        endcase
    end

    // Shift-add step: add multiplicand when the current multiplier bit is set
    assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Multiplier operand latch at accept, then one bit per BUSY cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= in_a;
            r_mplier <= in_b;
        end else if (r_state == c_BUSY) begin
            r_acc    <= w_acc_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

`ifdef ALU_MC_DIV_EN
    logic               r_div_op;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic               w_div_signed;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic [WIDTH-1:0]   w_div_res;
    logic               w_unused_sub_bit;

    assign w_div_signed = (instruction == c_IDIV) || (instruction == c_IREM);

    // Restoring step: shift next dividend bit in, subtract divisor if it fits
    assign w_rem_sh         = {r_rem, r_quo[WIDTH-1]};
    assign w_sub            = {1'b0, w_rem_sh} - {2'b00, r_dvsr};
    assign w_ge             = ~w_sub[WIDTH+1];
    assign w_rem_nx         = w_ge ? w_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx         = {r_quo[WIDTH-2:0], w_ge};
    assign w_unused_sub_bit = w_sub[WIDTH];

    // Final sign fix-up and divide-by-zero override
    always_comb begin
        w_div_res = r_is_rem ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                             : (r_neg_q ? -w_quo_nx : w_quo_nx);
        if (r_dz) begin
            w_div_res = r_is_rem ? r_a_orig : '1;
        end
    end

    // Divider operand latch (magnitudes and sign info) and iteration
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_div_op <= w_is_div;
            r_is_rem <= (instruction == c_IREM) || (instruction == c_IREMU);
            r_neg_q  <= w_div_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            r_neg_r  <= w_div_signed && in_a[WIDTH-1];
            r_dz     <= (in_b == '0);
            r_a_orig <= in_a;
            r_quo    <= (w_div_signed && in_a[WIDTH-1]) ? -in_a : in_a;
            r_dvsr   <= (w_div_signed && in_b[WIDTH-1]) ? -in_b : in_b;
            r_rem    <= '0;
        end else if (r_state == c_BUSY) begin
            r_quo    <= w_quo_nx;
            r_rem    <= w_rem_nx;
        end
    end

    assign w_iter_res = r_div_op ? w_div_res : w_acc_nx;
`else
    assign w_iter_res = w_acc_nx;
`endif

    // Result/flag register and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            if (!w_is_iter) begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_ovf    <= w_alu_ovf;
            end
        end else if (r_state == c_BUSY) begin
            r_cnt <= r_cnt + SHAMT_W'(1);
            if (w_last) begin
                r_result <= w_iter_res;
                r_zero   <= (w_iter_res == '0);
                r_ovf    <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_is_iter ? c_BUSY : c_DONE;
                end
            end
            c_BUSY: begin
                if (w_last) begin
                    w_state_nx = c_DONE;
                end
            end
            c_DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_state_nx = w_is_iter ? c_BUSY : c_DONE;
                    end else begin
                        w_state_nx = c_IDLE;
                    end
                end
            end
            default: w_state_nx = c_IDLE;
        endcase
    end

    // FSM outputs: ready when idle or when the held result drains this cycle
    always_comb begin
        in_ready  = !rst && ((r_state == c_IDLE) || ((r_state == c_DONE) && out_ready));
        out_valid = !rst && (r_state == c_DONE);
        result    = r_result;
        flag_zero = r_zero;
        flag_ovf  = r_ovf;
    end

endmodule
`default_nettype wire
